// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-add multiplier sequencer.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shift-add multiplier: loads operands, steps
// the operand-B shift register and commands the accumulator one bit per step.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic b_bit,
  output logic ready,
  output logic busy,
  output logic load_a,
  output logic load_b,
  output logic shift_b,
  output logic clr_acc,
  output logic add_en,
  output logic acc_shift,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Moore outputs are kept in flops, decoded from the next state so they
  // line up with the state register cycle for cycle.
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic load_q, load_d;
  logic shift_b_q, shift_b_d;
  logic acc_shift_q, acc_shift_d;
  logic done_q, done_d;

  // State, bit counter and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      shift_b_q   <= 1'b0;
      acc_shift_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      shift_b_q   <= shift_b_d;
      acc_shift_q <= acc_shift_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter update, Mealy add_en and next Moore output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_en      = 1'b0;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    load_d      = 1'b0;
    shift_b_d   = 1'b0;
    acc_shift_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        state_d = ADD;
      end
      ADD: begin
        add_en  = b_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_LAST) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel wins over every other transition.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    ready_d     = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    load_d      = (state_d == LOAD);
    shift_b_d   = (state_d == SHIFT);
    acc_shift_d = (state_d == ADD);
    done_d      = (state_d == DONE);
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign load_a    = load_q;
  assign load_b    = load_q;
  assign clr_acc   = load_q;
  assign shift_b   = shift_b_q;
  assign acc_shift = acc_shift_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: cycle-offset reference model, emulated
// operand-B shift register, directed scenarios and randomized stimulus.
module tb_mult_ctrl;

  localparam int W      = 4;
  localparam int DONE_T = 2 * W + 2;

  logic clk;
  logic rst, start, abort, b_bit;
  logic ready, busy, load_a, load_b, shift_b, clr_acc, add_en, acc_shift, done;

  int errs   = 0;
  int checks = 0;

  // Model: t = cycles since the accepted start (0 = idle, 1 = load,
  // even 2..2W = shift, odd 3..2W+1 = add, 2W+2 = done).
  int       t = 0;
  logic [3:0] breg = '0;
  logic [3:0] b_op = '0;
  bit       rand_b = 1'b0;
  logic     prev_acc = 1'b0;

  logic [63:0] m_add, m_acc, m_done, m_load;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .b_bit    (b_bit),
    .ready    (ready),
    .busy     (busy),
    .load_a   (load_a),
    .load_b   (load_b),
    .shift_b  (shift_b),
    .clr_acc  (clr_acc),
    .add_en   (add_en),
    .acc_shift(acc_shift),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %b expected %b (model t=%0d)", name, $time, act, exp, t);
    end
  endtask

  task automatic cmpv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_cycle();
    bit in_add, in_shift;
    in_add   = (t >= 3) && (t <= 2 * W + 1) && (t % 2 == 1);
    in_shift = (t >= 2) && (t <= 2 * W) && (t % 2 == 0);
    cmp1("ready",     ready,     t == 0);
    cmp1("busy",      busy,      t != 0);
    cmp1("load_a",    load_a,    t == 1);
    cmp1("load_b",    load_b,    t == 1);
    cmp1("clr_acc",   clr_acc,   t == 1);
    cmp1("shift_b",   shift_b,   in_shift);
    cmp1("acc_shift", acc_shift, in_add);
    cmp1("add_en",    add_en,    in_add && b_bit);
    cmp1("done",      done,      t == DONE_T);
    cmp1("onehot0_loadb_shiftb", $onehot0({load_b, shift_b}), 1'b1);
    cmp1("add_en_implies_acc_shift", !add_en || acc_shift, 1'b1);
    cmp1("done_after_add", !done || prev_acc, 1'b1);
    prev_acc = acc_shift;
  endtask

  // One clock: advance model on the edge, present b_bit, then check.
  task automatic step();
    int tp;
    @(posedge clk);
    #1;
    tp = t;
    if (!rst || abort)      t = 0;
    else if (t == 0)        t = start ? 1 : 0;
    else if (t == DONE_T)   t = 0;
    else                    t = t + 1;

    if (rst && tp == 1) breg = b_op;
    if (rst && tp >= 2 && tp <= 2 * W && tp % 2 == 0) begin
      b_bit = breg[0];
      breg  = breg >> 1;
    end else if (rand_b) begin
      b_bit = 1'($urandom_range(0, 1));
    end
    #1;
    compare_cycle();
  endtask

  task automatic go_idle();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic record(input int c);
    m_add[c]  = add_en;
    m_acc[c]  = acc_shift;
    m_done[c] = done;
    m_load[c] = load_a;
  endtask

  task automatic clear_masks();
    m_add = '0; m_acc = '0; m_done = '0; m_load = '0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; b_bit = 1'b0;

    // Reset values
    step();
    step();
    cmp1("reset_ready", ready, 1'b1);
    cmpv("reset_others", 64'({busy, load_a, load_b, shift_b, clr_acc, add_en, acc_shift, done}), 64'd0);
    rst = 1'b1;
    step();

    // B = 1011: adds in cycles 3,5,9, done in 10
    go_idle();
    clear_masks();
    b_op  = 4'b1011;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      record(c);
      if (c == 1) start = 1'b0;
    end
    cmpv("b1011_add_en_cycles",  m_add,  64'h228);
    cmpv("b1011_acc_shift_cycles", m_acc, 64'h2A8);
    cmpv("b1011_done_cycle",     m_done, 64'h400);
    cmpv("b1011_load_cycle",     m_load, 64'h2);

    // B = 0: four shifts, no adds, done in 10
    go_idle();
    clear_masks();
    b_op  = 4'b0000;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      record(c);
      if (c == 1) start = 1'b0;
    end
    cmpv("b0_add_en_never",   m_add, 64'd0);
    cmpv("b0_acc_shift_count", 64'($countones(m_acc)), 64'd4);
    cmpv("b0_done_cycle",     m_done, 64'h400);

    // start held high: back-to-back runs
    go_idle();
    clear_masks();
    b_op  = 4'b0110;
    start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step();
      record(c);
    end
    start = 1'b0;
    cmpv("b2b_done_cycles", m_done, (64'd1 << 10) | (64'd1 << 21) | (64'd1 << 32));
    cmpv("b2b_load_cycles", m_load, (64'd1 << 1) | (64'd1 << 12) | (64'd1 << 23));

    // abort in cycle 6, restart in cycle 7
    go_idle();
    clear_masks();
    b_op  = 4'b1111;
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      record(c);
      if (c == 1) start = 1'b0;
      if (c == 6) abort = 1'b1;
      if (c == 7) begin
        cmp1("abort_idle_c7", ready, 1'b1);
        abort = 1'b0;
        start = 1'b1;
      end
      if (c == 8) start = 1'b0;
    end
    cmpv("abort_done_cycles", m_done, 64'd1 << 17);
    cmpv("abort_load_cycles", m_load, (64'd1 << 1) | (64'd1 << 8));

    // Async reset during SHIFT (cycle 4): discarded, no done afterwards
    go_idle();
    clear_masks();
    b_op  = 4'b1010;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      record(c);
      if (c == 1) start = 1'b0;
      if (c == 4) begin
        cmp1("pre_reset_shift", shift_b, 1'b1);
        rst = 1'b0;
      end
      if (c == 5) cmp1("post_reset_ready", ready, 1'b1);
      if (c == 6) rst = 1'b1;
    end
    cmpv("reset_no_done", m_done, 64'd0);

    // Randomized stimulus
    rand_b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      b_op  = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
